// File: rtl/uart_ascii_pkg.sv
// Shared types and constants for the ASCII hex accumulator slice.
//   state_t      : accumulator FSM states (IDLE, ACCUM, HOLD, FLUSH)
//   char_class_t : classification of one received byte (DIGIT, TERM, SKIP, BAD)
//   CHAR_SPACE   : ignored separator character
//   CHAR_CR      : default terminator character
package uart_ascii_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2,
    FLUSH = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    DIGIT = 2'd0,
    TERM  = 2'd1,
    SKIP  = 2'd2,
    BAD   = 2'd3
  } char_class_t;

  localparam logic [7:0] CHAR_SPACE = 8'h20;
  localparam logic [7:0] CHAR_CR    = 8'h0D;

endpackage

// File: rtl/ascii_hex_decode.sv
// Combinational byte classifier: maps one ASCII byte to a character class
// and, for hex digits, the 4-bit value.
// Optional feature macro: ASCII_HEX_LOWERCASE_EN (accept 'a'-'f' as digits).
// Ports:
//   data : received ASCII byte
//   cls  : DIGIT, TERM (== TERM_CHAR), SKIP (space) or BAD
//   nib  : digit value, 0 when cls is not DIGIT
module ascii_hex_decode
  import uart_ascii_pkg::*;
#(
  parameter logic [7:0] TERM_CHAR = CHAR_CR
) (
  input  logic [7:0]  data,
  output char_class_t cls,
  output logic [3:0]  nib
);

  // Priority classification: terminator first so TERM_CHAR always ends a word.
  always_comb begin
    cls = BAD;
    nib = 4'h0;
    if (data == TERM_CHAR) begin
      cls = TERM;
    end else if (data == CHAR_SPACE) begin
      cls = SKIP;
    end else if ((data >= 8'h30) && (data <= 8'h39)) begin
      cls = DIGIT;
      nib = data[3:0];
    end else if ((data >= 8'h41) && (data <= 8'h46)) begin
      // 'A' has low nibble 1, so adding 9 yields 4'hA.
      cls = DIGIT;
      nib = data[3:0] + 4'h9;
`ifdef ASCII_HEX_LOWERCASE_EN
    end else if ((data >= 8'h61) && (data <= 8'h66)) begin
      cls = DIGIT;
      nib = data[3:0] + 4'h9;
`endif
    end else begin
      cls = BAD;
      nib = 4'h0;
    end
  end

endmodule

// File: rtl/ascii_hex_accumulator.sv
// Accumulates up to NUM_DIGITS ASCII hex digits (MSB first) from a UART byte
// stream into one right-aligned word presented on a valid/ready handshake.
// Optional feature macro: ASCII_HEX_LOWERCASE_EN (lowercase hex digits accepted).
// Ports:
//   clk, rst_n  : clock, synchronous active-low reset
//   rx_data     : received byte, qualified by rx_valid
//   rx_ready    : low only while a finished word is held
//   word_out    : accumulated word (qualify with word_valid)
//   word_valid  : finished word available, held until word_ready
//   word_ready  : consumer accept
//   digit_cnt   : digits collected in the current word
//   err         : one-cycle pulse on an invalid character
//   ovr         : one-cycle pulse when a byte arrives while rx_ready is low
module ascii_hex_accumulator
  import uart_ascii_pkg::*;
#(
  parameter int         NUM_DIGITS = 4,
  parameter logic [7:0] TERM_CHAR  = 8'h0D
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [7:0]                        rx_data,
  input  logic                              rx_valid,
  output logic                              rx_ready,
  output logic [4*NUM_DIGITS-1:0]           word_out,
  output logic                              word_valid,
  input  logic                              word_ready,
  output logic [$clog2(NUM_DIGITS+1)-1:0]   digit_cnt,
  output logic                              err,
  output logic                              ovr
);

  localparam int W  = 4 * NUM_DIGITS;
  localparam int CW = $clog2(NUM_DIGITS + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(NUM_DIGITS);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  state_t        state_r, state_s;
  logic [W-1:0]  acc_r, acc_s, shifted_s;
  logic [CW-1:0] cnt_r, cnt_s, cnt_inc_s;
  logic          word_valid_r, rx_ready_r, err_r, ovr_r;
  logic          err_s, ovr_s;
  char_class_t   cls_s;
  logic [3:0]    nib_s;

  ascii_hex_decode #(
    .TERM_CHAR (TERM_CHAR)
  ) u_decode (
    .data (rx_data),
    .cls  (cls_s),
    .nib  (nib_s)
  );

  // A single-digit word has nothing to shift out; avoid a negative slice.
  if (NUM_DIGITS == 1) begin : g_shift_one
    assign shifted_s = nib_s;
  end else begin : g_shift_many
    assign shifted_s = {acc_r[W-5:0], nib_s};
  end

  assign cnt_inc_s = cnt_r + CNT_ONE;

  // Next-state, accumulator and pulse logic.
  always_comb begin
    state_s = state_r;
    acc_s   = acc_r;
    cnt_s   = cnt_r;
    err_s   = 1'b0;
    ovr_s   = 1'b0;
    case (state_r)
      IDLE, ACCUM: begin
        if (rx_valid) begin
          case (cls_s)
            DIGIT: begin
              acc_s   = shifted_s;
              cnt_s   = cnt_inc_s;
              state_s = (cnt_inc_s == CNT_FULL) ? HOLD : ACCUM;
            end
            TERM: begin
              // An empty word is never produced from IDLE.
              if (state_r == ACCUM) begin
                state_s = HOLD;
              end else begin
                state_s = IDLE;
              end
            end
            SKIP: begin
              state_s = state_r;
            end
            BAD: begin
              err_s   = 1'b1;
              acc_s   = {W{1'b0}};
              cnt_s   = {CW{1'b0}};
              state_s = FLUSH;
            end
            default: begin
              state_s = state_r;
            end
          endcase
        end else begin
          state_s = state_r;
        end
      end
      HOLD: begin
        // Bytes here are dropped unclassified, so err cannot coincide with ovr.
        if (rx_valid) begin
          ovr_s = 1'b1;
        end else begin
          ovr_s = 1'b0;
        end
        if (word_valid_r && word_ready) begin
          state_s = IDLE;
          acc_s   = {W{1'b0}};
          cnt_s   = {CW{1'b0}};
        end else begin
          state_s = HOLD;
        end
      end
      FLUSH: begin
        if (rx_valid && (cls_s == TERM)) begin
          state_s = IDLE;
        end else begin
          state_s = FLUSH;
        end
      end
      default: begin
        state_s = IDLE;
        acc_s   = {W{1'b0}};
        cnt_s   = {CW{1'b0}};
      end
    endcase
  end

  // State, accumulator and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      acc_r        <= {W{1'b0}};
      cnt_r        <= {CW{1'b0}};
      word_valid_r <= 1'b0;
      rx_ready_r   <= 1'b1;
      err_r        <= 1'b0;
      ovr_r        <= 1'b0;
    end else begin
      state_r      <= state_s;
      acc_r        <= acc_s;
      cnt_r        <= cnt_s;
      word_valid_r <= (state_s == HOLD);
      rx_ready_r   <= (state_s != HOLD);
      err_r        <= err_s;
      ovr_r        <= ovr_s;
    end
  end

  assign word_out   = acc_r;
  assign word_valid = word_valid_r;
  assign rx_ready   = rx_ready_r;
  assign digit_cnt  = cnt_r;
  assign err        = err_r;
  assign ovr        = ovr_r;

endmodule

// File: tb/tb_ascii_hex_accumulator.sv
// Directed self-checking bench for ascii_hex_accumulator (NUM_DIGITS=4).
// Inputs change 1 time unit after the rising edge; outputs are checked there.
module tb_ascii_hex_accumulator;

  logic        clk;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [15:0] word_out;
  logic        word_valid;
  logic        word_ready;
  logic [2:0]  digit_cnt;
  logic        err;
  logic        ovr;

  int vectors;
  int miscompares;

  ascii_hex_accumulator #(
    .NUM_DIGITS (4),
    .TERM_CHAR  (8'h0D)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .word_out   (word_out),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .digit_cnt  (digit_cnt),
    .err        (err),
    .ovr        (ovr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    vectors++; if (word_valid !== 1'b0) begin miscompares++; $display("FAIL reset_word_valid: got %b want 0", word_valid); end
    vectors++; if (rx_ready !== 1'b1) begin miscompares++; $display("FAIL reset_rx_ready: got %b want 1", rx_ready); end
    vectors++; if (word_out !== 16'h0000) begin miscompares++; $display("FAIL reset_word_out: got %h want 0000", word_out); end
    vectors++; if (digit_cnt !== 3'd0) begin miscompares++; $display("FAIL reset_digit_cnt: got %0d want 0", digit_cnt); end
    vectors++; if ({err, ovr} !== 2'b00) begin miscompares++; $display("FAIL reset_err_ovr: got %b want 00", {err, ovr}); end
  endtask

  task automatic test_full_word();
    word_ready = 1'b1;
    send(8'h31); send(8'h41); send(8'h32);
    vectors++; if (digit_cnt !== 3'd3) begin miscompares++; $display("FAIL full_cnt3: got %0d want 3", digit_cnt); end
    vectors++; if (word_valid !== 1'b0) begin miscompares++; $display("FAIL full_early_valid: got %b want 0", word_valid); end
    send(8'h46);
    vectors++; if (word_valid !== 1'b1) begin miscompares++; $display("FAIL full_valid: got %b want 1", word_valid); end
    vectors++; if (word_out !== 16'h1A2F) begin miscompares++; $display("FAIL full_word_out: got %h want 1a2f", word_out); end
    vectors++; if (rx_ready !== 1'b0) begin miscompares++; $display("FAIL full_rx_ready: got %b want 0", rx_ready); end
    vectors++; if (digit_cnt !== 3'd4) begin miscompares++; $display("FAIL full_cnt4: got %0d want 4", digit_cnt); end
    tick();
    vectors++; if (word_valid !== 1'b0) begin miscompares++; $display("FAIL full_after_hs_valid: got %b want 0", word_valid); end
    vectors++; if (rx_ready !== 1'b1) begin miscompares++; $display("FAIL full_after_hs_ready: got %b want 1", rx_ready); end
    vectors++; if (word_out !== 16'h0000) begin miscompares++; $display("FAIL full_after_hs_clear: got %h want 0000", word_out); end
    // Terminator in IDLE is ignored: no empty word.
    send(8'h0D);
    vectors++; if ({word_valid, err, ovr} !== 3'b000) begin miscompares++; $display("FAIL idle_cr_ignored: got %b want 000", {word_valid, err, ovr}); end
    word_ready = 1'b0;
  endtask

  task automatic test_partial();
    word_ready = 1'b0;
    send(8'h37); send(8'h42); send(8'h0D);
    vectors++; if (word_valid !== 1'b1) begin miscompares++; $display("FAIL partial_valid: got %b want 1", word_valid); end
    vectors++; if (word_out !== 16'h007B) begin miscompares++; $display("FAIL partial_word_out: got %h want 007b", word_out); end
    vectors++; if (digit_cnt !== 3'd2) begin miscompares++; $display("FAIL partial_cnt: got %0d want 2", digit_cnt); end
    tick();
    vectors++; if ({word_valid, word_out} !== {1'b1, 16'h007B}) begin miscompares++; $display("FAIL partial_held: got %b/%h want 1/007b", word_valid, word_out); end
    word_ready = 1'b1;
    tick();
    word_ready = 1'b0;
    vectors++; if (word_valid !== 1'b0) begin miscompares++; $display("FAIL partial_released: got %b want 0", word_valid); end
  endtask

  task automatic test_flush();
    word_ready = 1'b0;
    send(8'h31); send(8'h32); send(8'h47);
    vectors++; if (err !== 1'b1) begin miscompares++; $display("FAIL flush_err_pulse: got %b want 1", err); end
    vectors++; if ({digit_cnt, word_out} !== {3'd0, 16'h0000}) begin miscompares++; $display("FAIL flush_clear: got %0d/%h want 0/0000", digit_cnt, word_out); end
    send(8'h34);
    vectors++; if ({err, digit_cnt} !== {1'b0, 3'd0}) begin miscompares++; $display("FAIL flush_discard: got %b/%0d want 0/0", err, digit_cnt); end
    send(8'h3A);
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL flush_no_second_err: got %b want 0", err); end
    send(8'h0D);
    vectors++; if ({word_valid, rx_ready} !== 2'b01) begin miscompares++; $display("FAIL flush_end: got %b want 01", {word_valid, rx_ready}); end
    send(8'h41); send(8'h42); send(8'h0D);
    vectors++; if ({word_valid, word_out} !== {1'b1, 16'h00AB}) begin miscompares++; $display("FAIL flush_next_word: got %b/%h want 1/00ab", word_valid, word_out); end
    word_ready = 1'b1;
    tick();
    word_ready = 1'b0;
    // '@' sits just below 'A' and must be invalid.
    send(8'h40);
    vectors++; if (err !== 1'b1) begin miscompares++; $display("FAIL at_sign_err: got %b want 1", err); end
    send(8'h0D);
  endtask

  task automatic test_hold_ovr();
    word_ready = 1'b0;
    send(8'h46); send(8'h46); send(8'h46); send(8'h46);
    vectors++; if ({word_valid, word_out} !== {1'b1, 16'hFFFF}) begin miscompares++; $display("FAIL hold_word: got %b/%h want 1/ffff", word_valid, word_out); end
    tick(); tick();
    send(8'h33);
    vectors++; if ({ovr, err} !== 2'b10) begin miscompares++; $display("FAIL hold_ovr_pulse: got %b want 10", {ovr, err}); end
    vectors++; if ({word_out, digit_cnt} !== {16'hFFFF, 3'd4}) begin miscompares++; $display("FAIL hold_stable: got %h/%0d want ffff/4", word_out, digit_cnt); end
    tick();
    vectors++; if (ovr !== 1'b0) begin miscompares++; $display("FAIL hold_ovr_one_cycle: got %b want 0", ovr); end
    // Terminator arriving on the handshake cycle is still dropped.
    word_ready = 1'b1;
    send(8'h0D);
    vectors++; if ({ovr, word_valid, rx_ready} !== 3'b101) begin miscompares++; $display("FAIL hs_cycle_ovr: got %b want 101", {ovr, word_valid, rx_ready}); end
    vectors++; if (digit_cnt !== 3'd0) begin miscompares++; $display("FAIL hs_cycle_cnt: got %0d want 0", digit_cnt); end
    word_ready = 1'b0;
    send(8'h33); send(8'h0D);
    vectors++; if ({word_valid, word_out} !== {1'b1, 16'h0003}) begin miscompares++; $display("FAIL after_ovr_word: got %b/%h want 1/0003", word_valid, word_out); end
    word_ready = 1'b1;
    tick();
    word_ready = 1'b0;
  endtask

  task automatic test_lowercase();
    word_ready = 1'b0;
    send(8'h61);
`ifdef ASCII_HEX_LOWERCASE_EN
    vectors++; if ({err, digit_cnt} !== {1'b0, 3'd1}) begin miscompares++; $display("FAIL lower_a_digit: got %b/%0d want 0/1", err, digit_cnt); end
    send(8'h35); send(8'h0D);
    vectors++; if ({word_valid, word_out} !== {1'b1, 16'h00A5}) begin miscompares++; $display("FAIL lower_word: got %b/%h want 1/00a5", word_valid, word_out); end
    word_ready = 1'b1;
    tick();
    word_ready = 1'b0;
`else
    vectors++; if ({err, digit_cnt} !== {1'b1, 3'd0}) begin miscompares++; $display("FAIL lower_a_invalid: got %b/%0d want 1/0", err, digit_cnt); end
    send(8'h35); send(8'h0D);
    vectors++; if ({word_valid, rx_ready} !== 2'b01) begin miscompares++; $display("FAIL lower_no_word: got %b want 01", {word_valid, rx_ready}); end
`endif
  endtask

  task automatic test_reset_and_space();
    word_ready = 1'b0;
    send(8'h31); send(8'h32);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    vectors++; if ({digit_cnt, word_out} !== {3'd0, 16'h0000}) begin miscompares++; $display("FAIL midword_reset: got %0d/%h want 0/0000", digit_cnt, word_out); end
    send(8'h39); send(8'h0D);
    vectors++; if ({word_valid, word_out} !== {1'b1, 16'h0009}) begin miscompares++; $display("FAIL post_reset_word: got %b/%h want 1/0009", word_valid, word_out); end
    // Reset while holding discards the word.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    vectors++; if ({word_valid, rx_ready} !== 2'b01) begin miscompares++; $display("FAIL hold_reset: got %b want 01", {word_valid, rx_ready}); end
    send(8'h31); send(8'h20);
    vectors++; if ({digit_cnt, err} !== {3'd1, 1'b0}) begin miscompares++; $display("FAIL space_ignored: got %0d/%b want 1/0", digit_cnt, err); end
    send(8'h32); send(8'h0D);
    vectors++; if ({word_valid, word_out} !== {1'b1, 16'h0012}) begin miscompares++; $display("FAIL space_word: got %b/%h want 1/0012", word_valid, word_out); end
    word_ready = 1'b1;
    tick();
    word_ready = 1'b0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    rx_data     = 8'h00;
    rx_valid    = 1'b0;
    word_ready  = 1'b0;
    test_reset();
    test_full_word();
    test_partial();
    test_flush();
    test_hold_ovr();
    test_lowercase();
    test_reset_and_space();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
